multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/multicycle_cpu.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_cpu.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
// Multicycle MIPS-subset CPU: each instruction steps through FETCH/DECODE/EXECUTE/MEM/WB.
// Instruction and data ports use a req/ready handshake held stable until ready.
module multicycle_cpu #(
    parameter int                DATA_W   = 32,
    parameter int                NREG     = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              nreset,
    output logic              imem_req,
    output logic [DATA_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [DATA_W-1:0] pc,
    output logic [2:0]        state,
    output logic              retired,
    output logic              halted,
    output logic              illegal
);

    localparam int                RW      = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] F_ADD    = 6'b100000;
    localparam logic [5:0] F_SUB    = 6'b100010;
    localparam logic [5:0] F_AND    = 6'b100100;
    localparam logic [5:0] F_OR     = 6'b100101;
    localparam logic [5:0] F_SLT    = 6'b101010;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_pc;
    logic [31:0]       r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_mdr;
    logic              r_retired;
    logic              r_halted;
    logic              r_illegal;
    logic [DATA_W-1:0] r_regs [NREG];

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [RW-1:0]     w_rs;
    logic [RW-1:0]     w_rt;
    logic [RW-1:0]     w_rd;
    logic [RW-1:0]     w_dest;
    logic [DATA_W-1:0] w_imm;
    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] w_alu;
    logic              w_legal;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];
    assign w_rs    = r_ir[21 +: RW];
    assign w_rt    = r_ir[16 +: RW];
    assign w_rd    = r_ir[11 +: RW];
    assign w_dest  = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_imm   = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};
    assign w_pc4   = r_pc + PC_STEP;

    always_comb begin
        // NOTE: default assignment first so every path drives w_legal and no latch is inferred.
        w_legal = 1'b0;
        case (w_op)
            OP_RTYPE: w_legal = (w_funct == F_ADD) || (w_funct == F_SUB) || (w_funct == F_AND) ||
                                (w_funct == F_OR)  || (w_funct == F_SLT);
            OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_HALT: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_alu = r_a + r_imm;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    // Requests drop combinationally while reset is held so no transfer can start or complete.
    assign imem_req   = (r_state == S_FETCH) && !nreset;
    assign imem_addr  = r_pc;
    assign dmem_req   = (r_state == S_MEM) && !nreset;
    assign dmem_we    = (r_state == S_MEM) && (w_op == OP_SW);
    assign dmem_addr  = r_alu;
    assign dmem_wdata = r_b;
    assign pc         = r_pc;
    assign state      = r_state;
    assign retired    = r_retired;
    assign halted     = r_halted;
    assign illegal    = r_illegal;

    always_ff @(posedge clk) begin
        if (nreset) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_imm     <= '0;
            r_alu     <= '0;
            r_mdr     <= '0;
            r_retired <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            // NOTE: the register file is cleared on reset, which keeps it in flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            r_retired <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ready) begin
                        r_ir    <= imem_rdata;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a   <= r_regs[w_rs];
                    r_b   <= r_regs[w_rt];
                    r_imm <= w_imm;
                    if (w_legal) begin
                        r_state <= S_EXECUTE;
                    end else begin
                        r_state   <= S_HALT;
                        r_halted  <= 1'b1;
                        r_illegal <= 1'b1;
                    end
                end
                S_EXECUTE: begin
                    case (w_op)
                        OP_BEQ: begin
                            r_pc      <= (r_a == r_b) ? w_pc4 + (r_imm << 2) : w_pc4;
                            r_retired <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                        OP_J: begin
                            r_pc      <= {w_pc4[DATA_W-1:28], r_ir[25:0], 2'b00};
                            r_retired <= 1'b1;
                            r_state   <= S_FETCH;
                        end
                        OP_HALT: begin
                            r_state  <= S_HALT;
                            r_halted <= 1'b1;
                        end
                        OP_LW, OP_SW: begin
                            r_alu   <= w_alu;
                            r_state <= S_MEM;
                        end
                        default: begin
                            r_alu   <= w_alu;
                            r_state <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (w_op == OP_SW) begin
                            r_pc      <= w_pc4;
                            r_retired <= 1'b1;
                            r_state   <= S_FETCH;
                        end else begin
                            r_mdr   <= dmem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_dest != '0) r_regs[w_dest] <= (w_op == OP_LW) ? r_mdr : r_alu;
                    r_pc      <= w_pc4;
                    r_retired <= 1'b1;
                    r_state   <= S_FETCH;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Self-checking bench for multicycle_cpu: wait-state memory models plus retire/store
// scoreboards; each scenario task pushes expectations and checks its own outcomes.
module tb_multicycle_cpu;

    localparam logic [5:0]  OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04, OP_J = 6'h02;
    localparam logic [5:0]  F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;
    localparam logic [31:0] HALT_WORD = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata, pc;
    logic [2:0]  state;
    logic        retired, halted, illegal;

    int checks = 0;
    int failures = 0;
    int imem_wait = 0;
    int dmem_wait = 0;
    int iw = 0;
    int dw = 0;

    logic [31:0] imem [0:127];
    logic [31:0] dmem [0:255];

    typedef struct { logic [31:0] npc; int lat; } ret_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } st_t;
    ret_t exp_ret[$];
    st_t  exp_st[$];

    multicycle_cpu dut (
        .clk(clk), .nreset(nreset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .state(state), .retired(retired), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        logic [4:0] s, t;
        logic [15:0] im;
        s = rs[4:0]; t = rt[4:0]; im = imm[15:0];
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] funct);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {6'h00, s, t, d, 5'd0, funct};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        logic [25:0] tg;
        tg = target[25:0];
        return {OP_J, tg};
    endfunction

    task automatic load_at(input logic [31:0] addr, input logic [31:0] ins, input logic [31:0] npc, input int lat);
        imem[addr[8:2]] = ins;
        exp_ret.push_back('{npc: npc, lat: lat});
    endtask

    task automatic add_st(input logic [31:0] addr, input logic [31:0] data);
        exp_st.push_back('{addr: addr, data: data});
    endtask

    task automatic hold_reset();
        @(posedge clk); #1 nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) imem[i] = HALT_WORD;
        exp_ret.delete();
        exp_st.delete();
    endtask

    task automatic release_reset();
        @(posedge clk); #1 nreset = 1'b0;
    endtask

    // Memory responders: ready rises after the configured number of wait cycles of a held request.
    initial begin
        imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (imem_req) begin
                if (iw >= imem_wait) begin
                    imem_ready = 1'b1; imem_rdata = imem[imem_addr[8:2]]; iw = 0;
                end else begin
                    imem_ready = 1'b0; iw++;
                end
            end else begin
                imem_ready = 1'b0; iw = 0;
            end
            if (dmem_req) begin
                if (dw >= dmem_wait) begin
                    dmem_ready = 1'b1; dw = 0;
                    if (dmem_we) dmem[dmem_addr[9:2]] = dmem_wdata;
                    else dmem_rdata = dmem[dmem_addr[9:2]];
                end else begin
                    dmem_ready = 1'b0; dw++;
                end
            end else begin
                dmem_ready = 1'b0; dw = 0;
            end
        end
    end

    // Scoreboard monitor: latency counts cycles from the first FETCH (or previous retire).
    initial begin
        ret_t er;
        st_t  es;
        int   lat;
        lat = -1;
        forever begin
            @(negedge clk);
            if (nreset) begin
                lat = -1;
            end else begin
                lat++;
                if (retired) begin
                    checks++;
                    if (exp_ret.size() == 0) begin
                        failures++;
                        $display("FAIL retire_unexpected: pc=%h, wanted no retire", pc);
                    end else begin
                        er = exp_ret.pop_front();
                        if (pc !== er.npc || lat !== er.lat) begin
                            failures++;
                            $display("FAIL retire: pc=%h lat=%0d, want pc=%h lat=%0d", pc, lat, er.npc, er.lat);
                        end
                    end
                    lat = 0;
                end
                if (dmem_req && dmem_ready && dmem_we) begin
                    checks++;
                    if (exp_st.size() == 0) begin
                        failures++;
                        $display("FAIL store_unexpected: addr=%h data=%h", dmem_addr, dmem_wdata);
                    end else begin
                        es = exp_st.pop_front();
                        if (dmem_addr !== es.addr || dmem_wdata !== es.data) begin
                            failures++;
                            $display("FAIL store: addr=%h data=%h, want addr=%h data=%h",
                                     dmem_addr, dmem_wdata, es.addr, es.data);
                        end
                    end
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 128; i++) imem[i] = HALT_WORD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", pc); end
        checks++; if ({retired, halted, illegal} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b want 000", {retired, halted, illegal});
        end
        checks++; if ({imem_req, dmem_req} !== 2'b00) begin
            failures++; $display("FAIL reset_req: got %b want 00", {imem_req, dmem_req});
        end
    endtask

    task automatic test_alu_mem();
        int c;
        hold_reset();
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        dmem[16] = 32'h7FFF_FFFF;
        imem_wait = 0; dmem_wait = 2;
        load_at(0,  enc_i(OP_ADDI, 0, 1, 5),    4, 4);
        load_at(4,  enc_i(OP_ADDI, 0, 2, -3),   8, 4);
        load_at(8,  enc_r(1, 2, 3, F_ADD),     12, 4);
        load_at(12, enc_i(OP_SW, 0, 3, 8),     16, 6); add_st(8, 32'd2);
        load_at(16, enc_i(OP_LW, 0, 4, 8),     20, 7);
        load_at(20, enc_i(OP_SW, 0, 4, 12),    24, 6); add_st(12, 32'd2);
        load_at(24, enc_i(OP_ADDI, 0, 0, 7),   28, 4);
        load_at(28, enc_r(2, 1, 5, F_SLT),     32, 4);
        load_at(32, enc_i(OP_SW, 0, 0, 16),    36, 6); add_st(16, 32'd0);
        load_at(36, enc_i(OP_SW, 0, 5, 20),    40, 6); add_st(20, 32'd1);
        load_at(40, enc_i(OP_LW, 0, 6, 'h40),  44, 7);
        load_at(44, enc_i(OP_ADDI, 6, 7, 1),   48, 4);
        load_at(48, enc_i(OP_SW, 0, 7, 24),    52, 6); add_st(24, 32'h8000_0000);
        load_at(52, enc_r(1, 2, 8, F_SUB),     56, 4);
        load_at(56, enc_r(1, 2, 9, F_OR),      60, 4);
        load_at(60, enc_r(9, 8, 10, F_AND),    64, 4);
        load_at(64, enc_i(OP_SW, 0, 8, 28),    68, 6); add_st(28, 32'd8);
        load_at(68, enc_i(OP_SW, 0, 9, 32),    72, 6); add_st(32, 32'hFFFF_FFFD);
        load_at(72, enc_i(OP_SW, 0, 10, 36),   76, 6); add_st(36, 32'd8);
        release_reset();
        c = 0;
        while ((exp_ret.size() != 0 || exp_st.size() != 0 || halted !== 1'b1) && c < 500) begin
            @(posedge clk); #1; c++;
        end
        checks++; if (c >= 500) begin failures++; $display("FAIL alu_mem_timeout: %0d retires left, want 0", exp_ret.size()); end
        checks++; if (pc !== 32'd76 || illegal !== 1'b0) begin
            failures++; $display("FAIL alu_mem_halt: pc=%h illegal=%b, want pc=0000004c illegal=0", pc, illegal);
        end
    endtask

    task automatic test_regs_cleared();
        int c;
        hold_reset();
        dmem_wait = 0;
        load_at(0, enc_i(OP_SW, 0, 3, 0), 4, 4); add_st(0, 32'd0);
        load_at(4, enc_i(OP_SW, 0, 9, 4), 8, 4); add_st(4, 32'd0);
        release_reset();
        c = 0;
        while ((exp_ret.size() != 0 || halted !== 1'b1) && c < 100) begin @(posedge clk); #1; c++; end
        checks++; if (c >= 100 || pc !== 32'd8) begin
            failures++; $display("FAIL regs_cleared: pc=%h cycles=%0d, want pc=00000008", pc, c);
        end
    endtask

    task automatic test_branch_jump();
        int c;
        hold_reset();
        imem_wait = 1; dmem_wait = 0;
        load_at(32'h000, enc_i(OP_ADDI, 0, 1, 5), 32'h004, 5);
        load_at(32'h004, enc_i(OP_BEQ, 1, 2, 3),  32'h008, 4);
        load_at(32'h008, enc_j(32'h40),           32'h100, 4);
        load_at(32'h100, enc_i(OP_BEQ, 1, 1, 2),  32'h10C, 4);
        load_at(32'h10C, enc_j(32'h8),            32'h020, 4);
        load_at(32'h020, enc_i(OP_BEQ, 1, 1, -1), 32'h020, 4);
        exp_ret.push_back('{npc: 32'h020, lat: 4});
        release_reset();
        c = 0;
        while (exp_ret.size() != 0 && c < 200) begin @(posedge clk); #1; c++; end
        checks++; if (c >= 200) begin failures++; $display("FAIL branch_timeout: %0d retires left, want 0", exp_ret.size()); end
        checks++; if (pc !== 32'h20 || halted !== 1'b0) begin
            failures++; $display("FAIL branch_loop: pc=%h halted=%b, want pc=00000020 halted=0", pc, halted);
        end
        imem_wait = 0;
    endtask

    task automatic test_halt();
        int c;
        logic bad;
        hold_reset();
        release_reset();
        c = 0;
        while (halted !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
        checks++; if (c !== 3 || state !== 3'd5 || illegal !== 1'b0 || pc !== 32'h0) begin
            failures++; $display("FAIL halt: cycles=%0d state=%0d illegal=%b pc=%h, want 3 5 0 0", c, state, illegal, pc);
        end
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req || dmem_req || retired || pc !== 32'h0 || halted !== 1'b1) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin failures++; $display("FAIL halt_absorbing: activity=%b want 0", bad); end

        hold_reset();
        imem[0] = {6'h3E, 26'h0};
        release_reset();
        c = 0;
        while (halted !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
        checks++; if (c !== 2 || state !== 3'd5 || illegal !== 1'b1) begin
            failures++; $display("FAIL illegal_op: cycles=%0d state=%0d illegal=%b, want 2 5 1", c, state, illegal);
        end

        hold_reset();
        imem[0] = enc_r(1, 2, 3, 6'h3F);
        release_reset();
        c = 0;
        while (halted !== 1'b1 && c < 20) begin @(posedge clk); #1; c++; end
        checks++; if (c !== 2 || illegal !== 1'b1) begin
            failures++; $display("FAIL illegal_funct: cycles=%0d illegal=%b, want 2 1", c, illegal);
        end
    endtask

    task automatic test_reset_mid_mem();
        int c;
        hold_reset();
        for (int i = 0; i < 256; i++) dmem[i] = '0;
        dmem_wait = 100;
        load_at(0, enc_i(OP_ADDI, 0, 1, 9), 4, 4);
        imem[1] = enc_i(OP_SW, 0, 1, 4);
        release_reset();
        c = 0;
        while (state !== 3'd3 && c < 30) begin @(posedge clk); #1; c++; end
        checks++; if (c >= 30) begin failures++; $display("FAIL mid_mem_reach: state=%0d want 3", state); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'd4 || dmem_wdata !== 32'd9) begin
            failures++; $display("FAIL mid_mem_hold: req=%b we=%b addr=%h data=%h, want 1 1 4 9",
                                 dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        nreset = 1'b1;
        @(posedge clk); #1;
        checks++; if (dmem_req !== 1'b0 || state !== 3'd0 || pc !== 32'h0) begin
            failures++; $display("FAIL mid_mem_reset: req=%b state=%0d pc=%h, want 0 0 0", dmem_req, state, pc);
        end
        checks++; if (dmem[1] !== 32'h0) begin failures++; $display("FAIL mid_mem_nowrite: mem=%h want 0", dmem[1]); end
        for (int i = 0; i < 128; i++) imem[i] = HALT_WORD;
        exp_ret.delete();
        exp_st.delete();
        dmem_wait = 0;
        load_at(0, enc_i(OP_SW, 0, 1, 0), 4, 4); add_st(0, 32'd0);
        release_reset();
        c = 0;
        while ((exp_ret.size() != 0 || halted !== 1'b1) && c < 100) begin @(posedge clk); #1; c++; end
        checks++; if (c >= 100 || pc !== 32'd4) begin
            failures++; $display("FAIL mid_mem_after: pc=%h cycles=%0d, want pc=00000004", pc, c);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_mem();
        test_regs_cleared();
        test_branch_jump();
        test_halt();
        test_reset_mid_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
